// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - bus-initiating byte-copy DMA engine with IO register window
module dma_engine #(
    parameter logic [7:0] DMA_ADDRESS = 8'h10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic [7:0]  address,
    input  logic        w_en,
    input  logic        r_en,
    output logic [7:0]  dout,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] m_address,
    output logic [7:0]  m_dout,
    output logic        m_w_en,
    output logic        m_r_en,
    input  logic [7:0]  m_din,
    output logic        done_flag,
    input  logic        done_flag_clr
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] READ    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;

    logic [2:0]  state;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  count;
    logic [7:0]  buffer;
    logic        inc_src;
    logic        inc_dst;

    logic [7:0]  offset;
    logic        hit;
    logic        busy;
    logic        ctrl_wr;
    logic        start_wr;
    logic        data_reg_wr;
    logic        last_byte;
    logic        done_set;
    logic        done_clr;
    logic [7:0]  rdata;
    logic        unused_din;

    // Offset wraps for addresses below the window, so a single compare covers both ends.
    assign offset      = address - DMA_ADDRESS;
    assign hit         = offset < 8'd6;
    assign busy        = state != IDLE;
    assign ctrl_wr     = w_en && hit && (offset == 8'd5);
    assign start_wr    = ctrl_wr && din[0] && !busy;
    assign data_reg_wr = w_en && hit && (offset != 8'd5) && !busy;
    assign last_byte   = (state == WRITE) && (count == 8'd1);
    assign done_set    = (start_wr && (count == 8'd0)) || last_byte;
    assign done_clr    = done_flag_clr || (ctrl_wr && din[2]);
    assign unused_din  = &{1'b0, din[7:5], din[1]};

    // Programmable registers; the transfer itself advances SRC/DST/COUNT after each write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src     <= 16'h0000;
            dst     <= 16'h0000;
            count   <= 8'h00;
            inc_src <= 1'b0;
            inc_dst <= 1'b0;
            buffer  <= 8'h00;
        end else begin
            if (data_reg_wr) begin
                case (offset)
                    8'd0:    src[7:0]  <= din;
                    8'd1:    src[15:8] <= din;
                    8'd2:    dst[7:0]  <= din;
                    8'd3:    dst[15:8] <= din;
                    default: count     <= din;
                endcase
            end
            if (ctrl_wr) begin
                inc_src <= din[3];
                inc_dst <= din[4];
            end
            if (state == CAPTURE) begin
                buffer <= m_din;
            end
            if (state == WRITE) begin
                count <= count - 8'd1;
                src   <= src + {15'h0000, inc_src};
                dst   <= dst + {15'h0000, inc_dst};
            end
        end
    end

    // Transfer sequencer: grant is only looked at in REQ and when leaving WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start_wr && (count != 8'd0)) state <= REQ;
                REQ:     if (bus_gnt) state <= READ;
                READ:    state <= CAPTURE;
                CAPTURE: state <= WRITE;
                WRITE: begin
                    if (count == 8'd1)  state <= IDLE;
                    else if (bus_gnt)   state <= READ;
                    else                state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion flag: a new completion wins over any clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)        done_flag <= 1'b0;
        else if (done_set) done_flag <= 1'b1;
        else if (done_clr) done_flag <= 1'b0;
    end

    // Register read mux; values are live so software can watch progress.
    always_comb begin
        rdata = 8'h00;
        case (offset)
            8'd0:    rdata = src[7:0];
            8'd1:    rdata = src[15:8];
            8'd2:    rdata = dst[7:0];
            8'd3:    rdata = dst[15:8];
            8'd4:    rdata = count;
            8'd5:    rdata = {3'b000, inc_dst, inc_src, done_flag, busy, 1'b0};
            default: rdata = 8'h00;
        endcase
    end

    // Registered read data, zero when not addressed so it can be OR-combined upstream.
    always_ff @(posedge clk) begin
        if (!rst_n) dout <= 8'h00;
        else        dout <= (r_en && hit) ? rdata : 8'h00;
    end

    // Master-side outputs decoded purely from state.
    always_comb begin
        bus_req   = busy;
        m_address = 16'h0000;
        m_dout    = 8'h00;
        m_r_en    = 1'b0;
        m_w_en    = 1'b0;
        if (state == READ) begin
            m_address = src;
            m_r_en    = 1'b1;
        end else if (state == WRITE) begin
            m_address = dst;
            m_dout    = buffer;
            m_w_en    = 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - scoreboard testbench for dma_engine
module tb_dma_engine;

    localparam logic [7:0] BASE = 8'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  address = 8'h00;
    logic        w_en = 1'b0;
    logic        r_en = 1'b0;
    logic [7:0]  dout;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] m_address;
    logic [7:0]  m_dout;
    logic        m_w_en;
    logic        m_r_en;
    logic [7:0]  m_din = 8'h00;
    logic        done_flag;
    logic        done_flag_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int req_cycles = 0;
    logic [24:0] exp_q[$];
    logic [7:0]  mem [0:65535];

    dma_engine #(.DMA_ADDRESS(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
        .dout(dout), .bus_req(bus_req), .bus_gnt(bus_gnt), .m_address(m_address),
        .m_dout(m_dout), .m_w_en(m_w_en), .m_r_en(m_r_en), .m_din(m_din),
        .done_flag(done_flag), .done_flag_clr(done_flag_clr)
    );

    always #5 clk = ~clk;

    // RAM model: read data appears the cycle after m_r_en
    always @(posedge clk) m_din <= m_r_en ? mem[m_address] : 8'h00;

    // Scoreboard monitor: every master strobe is popped against the expected list
    always @(negedge clk) begin
        logic [24:0] e;
        logic [24:0] got;
        if (bus_req) req_cycles++;
        if (m_r_en && m_w_en) begin
            errors++;
            $display("FAIL strobe_overlap: m_r_en=1 m_w_en=1 required not both");
        end
        if (m_r_en || m_w_en) begin
            checks++;
            got = {m_w_en, m_address, m_w_en ? m_dout : 8'h00};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got w=%0b addr=%h data=%h required no access", got[24], got[23:8], got[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_access: got w=%0b addr=%h data=%h required w=%0b addr=%h data=%h",
                             got[24], got[23:8], got[7:0], e[24], e[23:8], e[7:0]);
                end
            end
        end
    end

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        @(posedge clk); #1;
        address = BASE + off; din = d; w_en = 1'b1;
        @(posedge clk); #1;
        w_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [7:0] d);
        @(posedge clk); #1;
        address = BASE + off; r_en = 1'b1;
        @(posedge clk); #1;
        r_en = 1'b0;
        d = dout;
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [7:0] c, input logic [7:0] ctrl);
        wr(8'd0, s[7:0]); wr(8'd1, s[15:8]); wr(8'd2, d[7:0]); wr(8'd3, d[15:8]);
        wr(8'd4, c); wr(8'd5, ctrl);
    endtask

    task automatic exp_rd(input logic [15:0] a);
        exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_flag && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!done_flag) begin errors++; $display("FAIL %s_timeout: done_flag=%0b required 1", name, done_flag); end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        bus_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem[16'h0900 + i] = 8'h90 + i[7:0];
            exp_rd(16'h0900 + i[15:0]);
            exp_wr(16'h0A00 + i[15:0], 8'h90 + i[7:0]);
        end
        prog(16'h0900, 16'h0A00, 8'd5, 8'h19);
        repeat (4) @(posedge clk); #1;
        address = BASE + 8'd5; r_en = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus_req, m_r_en, m_w_en, done_flag, dout} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b r=%0b w=%0b done=%0b dout=%h required all 0",
                     bus_req, m_r_en, m_w_en, done_flag, dout);
        end
        @(posedge clk); #1 rst_n = 1'b1; r_en = 1'b0;
        exp_q.delete();
        rd(8'd5, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h required 00", v); end
        rd(8'd4, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_count: got %h required 00", v); end
    endtask

    task automatic test_copy();
        logic [7:0] v;
        mem[16'h0100] = 8'hAA; mem[16'h0101] = 8'hBB; mem[16'h0102] = 8'hCC;
        exp_rd(16'h0100); exp_wr(16'h0200, 8'hAA);
        exp_rd(16'h0101); exp_wr(16'h0201, 8'hBB);
        exp_rd(16'h0102); exp_wr(16'h0202, 8'hCC);
        bus_gnt = 1'b1;
        req_cycles = 0;
        prog(16'h0100, 16'h0200, 8'd3, 8'h19);
        wait_done("copy");
        repeat (2) @(negedge clk);
        checks++;
        if (req_cycles != 10) begin errors++; $display("FAIL copy_req_cycles: got %0d required 10", req_cycles); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL copy_missing: %0d accesses left required 0", exp_q.size()); end
        rd(8'd5, v);
        checks++;
        if (v !== 8'h1C) begin errors++; $display("FAIL copy_ctrl: got %h required 1C", v); end
        @(posedge clk); #1 done_flag_clr = 1'b1;
        @(posedge clk); #1 done_flag_clr = 1'b0;
        checks++;
        if (done_flag !== 1'b0) begin errors++; $display("FAIL copy_clr: got %0b required 0", done_flag); end
    endtask

    task automatic test_grant();
        int n;
        mem[16'h0300] = 8'h31; mem[16'h0301] = 8'h32;
        exp_rd(16'h0300); exp_wr(16'h0400, 8'h31);
        exp_rd(16'h0301); exp_wr(16'h0401, 8'h32);
        bus_gnt = 1'b0;
        prog(16'h0300, 16'h0400, 8'd2, 8'h19);
        repeat (5) @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || exp_q.size() != 4) begin
            errors++;
            $display("FAIL grant_wait: req=%0b pending=%0d required req=1 pending=4", bus_req, exp_q.size());
        end
        @(posedge clk); #1 bus_gnt = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_r_en && n < 20);
        @(posedge clk); #1 bus_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (m_r_en !== 1'b0 || m_w_en !== 1'b0) begin errors++; $display("FAIL grant_capture: r=%0b w=%0b required 0 0", m_r_en, m_w_en); end
        @(negedge clk);
        checks++;
        if (m_w_en !== 1'b1) begin errors++; $display("FAIL grant_write: w=%0b required 1", m_w_en); end
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || m_r_en !== 1'b0) begin errors++; $display("FAIL grant_rereq: req=%0b r=%0b required 1 0", bus_req, m_r_en); end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 2) begin errors++; $display("FAIL grant_hold: pending=%0d required 2", exp_q.size()); end
        @(posedge clk); #1 bus_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (m_r_en !== 1'b0) begin errors++; $display("FAIL grant_req_cycle: r=%0b required 0", m_r_en); end
        @(negedge clk);
        checks++;
        if (m_r_en !== 1'b1 || m_address !== 16'h0301) begin
            errors++;
            $display("FAIL grant_resume: r=%0b addr=%h required 1 0301", m_r_en, m_address);
        end
        wait_done("grant");
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL grant_missing: %0d left required 0", exp_q.size()); end
        wr(8'd5, 8'h04);
    endtask

    task automatic test_fixed_dst();
        logic [7:0] v;
        logic [7:0] want [5];
        mem[16'h0500] = 8'h11; mem[16'h0501] = 8'h22;
        exp_rd(16'h0500); exp_wr(16'h100A, 8'h11);
        exp_rd(16'h0501); exp_wr(16'h100A, 8'h22);
        bus_gnt = 1'b1;
        prog(16'h0500, 16'h100A, 8'd2, 8'h09);
        wait_done("fixed");
        want = '{8'h02, 8'h05, 8'h0A, 8'h10, 8'h00};
        for (int i = 0; i < 5; i++) begin
            rd(i[7:0], v);
            checks++;
            if (v !== want[i]) begin errors++; $display("FAIL fixed_reg%0d: got %h required %h", i, v, want[i]); end
        end
        rd(8'd5, v);
        checks++;
        if (v !== 8'h0C) begin errors++; $display("FAIL fixed_ctrl: got %h required 0C", v); end
        wr(8'd5, 8'h04);
    endtask

    task automatic test_edge_cases();
        logic [7:0] v;
        int n;
        wr(8'd4, 8'd0);
        wr(8'd5, 8'h19);
        @(negedge clk);
        checks++;
        if (done_flag !== 1'b1 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL zero_count: done=%0b req=%0b required 1 0", done_flag, bus_req);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus_req !== 1'b0) begin errors++; $display("FAIL zero_count_idle: req=%0b required 0", bus_req); end
        wr(8'd5, 8'h04);

        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
        exp_rd(16'hFFFF); exp_wr(16'h0600, 8'h5A);
        exp_rd(16'h0000); exp_wr(16'h0601, 8'hA5);
        prog(16'hFFFF, 16'h0600, 8'd2, 8'h19);
        wait_done("wrap");
        rd(8'd0, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL wrap_src_l: got %h required 01", v); end
        rd(8'd1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL wrap_src_h: got %h required 00", v); end
        wr(8'd5, 8'h04);

        mem[16'h0700] = 8'h77;
        exp_rd(16'h0700); exp_wr(16'h0800, 8'h77);
        prog(16'h0700, 16'h0800, 8'd1, 8'h19);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_w_en && n < 20);
        done_flag_clr = 1'b1;
        @(posedge clk); #1 done_flag_clr = 1'b0;
        checks++;
        if (done_flag !== 1'b1) begin errors++; $display("FAIL set_beats_clr: done=%0b required 1", done_flag); end
        @(posedge clk); #1 done_flag_clr = 1'b1;
        @(posedge clk); #1 done_flag_clr = 1'b0;
        checks++;
        if (done_flag !== 1'b0) begin errors++; $display("FAIL clr_after: done=%0b required 0", done_flag); end
    endtask

    task automatic test_busy_protect();
        logic [7:0] v;
        for (int i = 0; i < 3; i++) begin
            mem[16'h0B00 + i] = 8'hB0 + i[7:0];
            exp_rd(16'h0B00 + i[15:0]);
            exp_wr(16'h0C00 + i[15:0], 8'hB0 + i[7:0]);
        end
        bus_gnt = 1'b1;
        req_cycles = 0;
        prog(16'h0B00, 16'h0C00, 8'd3, 8'h19);
        wr(8'd4, 8'd9);
        wr(8'd0, 8'h55);
        wr(8'd5, 8'h19);
        wait_done("busy");
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || req_cycles != 10) begin
            errors++;
            $display("FAIL busy_transfer: pending=%0d req_cycles=%0d required 0 10", exp_q.size(), req_cycles);
        end
        rd(8'd4, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL busy_count: got %h required 00", v); end
        rd(8'd0, v);
        checks++;
        if (v !== 8'h03) begin errors++; $display("FAIL busy_src_l: got %h required 03", v); end
        wr(8'd5, 8'h1C);
        @(negedge clk);
        checks++;
        if (done_flag !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL busy_done_clr: done=%0b req=%0b required 0 0", done_flag, bus_req);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_grant();
        test_fixed_dst();
        test_edge_cases();
        test_busy_protect();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
